// File: rtl/time_alarm_ctrl_pkg.sv
// Shared definitions for the time-of-day clock and alarm ring controller:
// ring FSM encoding, BCD limits, default timing and BCD helper functions.
package time_alarm_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2,
      ST_HOLD   = 2'd3
   } ring_state_t;

   localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
   localparam logic [7:0] BCD_MIN_MAX  = 8'h59;

   localparam int DEF_RING_SECS   = 60;
   localparam int DEF_SNOOZE_SECS = 300;

   // Both digits must be decimal; with valid digits, packed BCD orders like binary.
   function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   // Increment a packed BCD pair; the caller handles the modulo wrap.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/time_alarm_ctrl_counter60.sv
// Modulo-60 packed BCD counter used for seconds and minutes. A load takes
// priority over counting and suppresses the carry for that cycle.
module bcd_counter60
   import time_alarm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       en,
   output logic [7:0] value,
   output logic       carry
);

   assign carry = en && !load && (value == BCD_MIN_MAX);

   // Load wins over enable; 59 wraps to 00.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         value <= 8'h00;
      end else if (load) begin
         value <= load_val;
      end else if (en) begin
         value <= (value == BCD_MIN_MAX) ? 8'h00 : bcd_inc(value);
      end
   end

endmodule

// File: rtl/time_alarm_ctrl.sv
// Time-of-day clock (hh:mm:ss packed BCD) with keypad loads and an alarm
// ring controller supporting stop, snooze and ring timeout.
module time_alarm_ctrl
   import time_alarm_ctrl_pkg::*;
#(
   parameter int RING_SECS   = DEF_RING_SECS,
   parameter int SNOOZE_SECS = DEF_SNOOZE_SECS
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tick_1hz,
   input  logic       set_hour_stb,
   input  logic       set_min_stb,
   input  logic [7:0] new_hour,
   input  logic [7:0] new_minute,
   input  logic       alarm_en,
   input  logic [7:0] alarm_hour,
   input  logic [7:0] alarm_minute,
   input  logic       stop_key,
   input  logic       snooze_key,
   output logic [7:0] hour,
   output logic [7:0] minute,
   output logic [7:0] second,
   output logic       ring,
   output logic       snoozing
);

   localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECS);
   localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   ring_state_t      state;
   logic [CNT_W-1:0] cnt;

   logic hour_ok;
   logic min_ok;
   logic sec_carry;
   logic min_carry;
   logic match;
   logic at_alarm_time;

   // Invalid load values are dropped entirely.
   assign hour_ok = set_hour_stb && bcd_valid(new_hour, BCD_HOUR_MAX);
   assign min_ok  = set_min_stb  && bcd_valid(new_minute, BCD_MIN_MAX);

   assign at_alarm_time = (hour == alarm_hour) && (minute == alarm_minute);
   assign match         = alarm_en && at_alarm_time;

   // A minute load clears seconds, and its load suppresses the tick carry.
   bcd_counter60 u_sec (
      .clk      (clk),
      .rstn     (rstn),
      .load     (min_ok),
      .load_val (8'h00),
      .en       (tick_1hz),
      .value    (second),
      .carry    (sec_carry)
   );

   bcd_counter60 u_min (
      .clk      (clk),
      .rstn     (rstn),
      .load     (min_ok),
      .load_val (new_minute),
      .en       (sec_carry),
      .value    (minute),
      .carry    (min_carry)
   );

   // Hour register: a load discards any carry arriving in the same clk.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hour <= 8'h00;
      end else if (hour_ok) begin
         hour <= new_hour;
      end else if (min_carry) begin
         hour <= (hour == BCD_HOUR_MAX) ? 8'h00 : bcd_inc(hour);
      end
   end

   // Ring FSM with registered outputs; cnt counts down remaining ring/snooze ticks.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_HOLD;
         cnt      <= '0;
         ring     <= 1'b0;
         snoozing <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (match) begin
                  state <= ST_RING;
                  cnt   <= RING_LOAD;
                  ring  <= 1'b1;
               end
            end
            ST_RING: begin
               if (!alarm_en || stop_key) begin
                  state <= ST_HOLD;
                  cnt   <= '0;
                  ring  <= 1'b0;
               end else if (snooze_key) begin
                  state    <= ST_SNOOZE;
                  cnt      <= SNOOZE_LOAD;
                  ring     <= 1'b0;
                  snoozing <= 1'b1;
               end else if (tick_1hz) begin
                  if (cnt <= CNT_ONE) begin
                     state <= ST_HOLD;
                     cnt   <= '0;
                     ring  <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            ST_SNOOZE: begin
               if (stop_key || !alarm_en) begin
                  state    <= ST_HOLD;
                  cnt      <= '0;
                  snoozing <= 1'b0;
               end else if (tick_1hz) begin
                  if (cnt <= CNT_ONE) begin
                     state    <= ST_RING;
                     cnt      <= RING_LOAD;
                     ring     <= 1'b1;
                     snoozing <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            ST_HOLD: begin
               // Wait for the alarm minute to pass so it cannot re-trigger.
               if (!at_alarm_time) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_HOLD;
               cnt      <= '0;
               ring     <= 1'b0;
               snoozing <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time_alarm_ctrl.sv
// Bench for time_alarm_ctrl: directed scenarios followed by random stimulus,
// all checked against a seconds-since-midnight behavioural model.
module tb_time_alarm_ctrl;

   localparam int RING_SECS   = 60;
   localparam int SNOOZE_SECS = 300;

   localparam int M_IDLE    = 0;
   localparam int M_RINGING = 1;
   localparam int M_SNOOZED = 2;
   localparam int M_HELD    = 3;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tick_1hz;
   logic       set_hour_stb;
   logic       set_min_stb;
   logic [7:0] new_hour;
   logic [7:0] new_minute;
   logic       alarm_en;
   logic [7:0] alarm_hour;
   logic [7:0] alarm_minute;
   logic       stop_key;
   logic       snooze_key;
   logic [7:0] hour;
   logic [7:0] minute;
   logic [7:0] second;
   logic       ring;
   logic       snoozing;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_sec;
   int m_mode;
   int m_elapsed;

   time_alarm_ctrl #(
      .RING_SECS   (RING_SECS),
      .SNOOZE_SECS (SNOOZE_SECS)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .tick_1hz     (tick_1hz),
      .set_hour_stb (set_hour_stb),
      .set_min_stb  (set_min_stb),
      .new_hour     (new_hour),
      .new_minute   (new_minute),
      .alarm_en     (alarm_en),
      .alarm_hour   (alarm_hour),
      .alarm_minute (alarm_minute),
      .stop_key     (stop_key),
      .snooze_key   (snooze_key),
      .hour         (hour),
      .minute       (minute),
      .second       (second),
      .ring         (ring),
      .snoozing     (snoozing)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int n);
      return 8'(((n / 10) * 16) + (n % 10));
   endfunction

   function automatic bit load_ok(input logic [7:0] v, input int limit);
      int hi;
      int lo;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      return (hi <= 9) && (lo <= 9) && ((hi * 10 + lo) <= limit);
   endfunction

   function automatic int bcd_val(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [23:0] model_time();
      return {to_bcd(m_sec / 3600), to_bcd((m_sec / 60) % 60), to_bcd(m_sec % 60)};
   endfunction

   task automatic model_reset();
      m_sec     = 0;
      m_mode    = M_HELD;
      m_elapsed = 0;
   endtask

   // Advance the model by one clk using the inputs currently applied.
   task automatic model_update();
      int  h, m, s;
      bit  at_time, hv, mv;
      h = m_sec / 3600;
      m = (m_sec / 60) % 60;
      s = m_sec % 60;
      at_time = (to_bcd(h) == alarm_hour) && (to_bcd(m) == alarm_minute);

      case (m_mode)
         M_IDLE: begin
            if (alarm_en && at_time) begin
               m_mode    = M_RINGING;
               m_elapsed = 0;
            end
         end
         M_RINGING: begin
            if (!alarm_en || stop_key) m_mode = M_HELD;
            else if (snooze_key) begin
               m_mode    = M_SNOOZED;
               m_elapsed = 0;
            end else if (tick_1hz) begin
               m_elapsed++;
               if (m_elapsed == RING_SECS) m_mode = M_HELD;
            end
         end
         M_SNOOZED: begin
            if (stop_key || !alarm_en) m_mode = M_HELD;
            else if (tick_1hz) begin
               m_elapsed++;
               if (m_elapsed == SNOOZE_SECS) begin
                  m_mode    = M_RINGING;
                  m_elapsed = 0;
               end
            end
         end
         default: begin
            if (!at_time) m_mode = M_IDLE;
         end
      endcase

      hv = set_hour_stb && load_ok(new_hour, 23);
      mv = set_min_stb && load_ok(new_minute, 59);
      if (mv) begin
         m = bcd_val(new_minute);
         s = 0;
      end else if (tick_1hz) begin
         s++;
         if (s == 60) begin
            s = 0;
            m++;
            if (m == 60) begin
               m = 0;
               h = (h + 1) % 24;
            end
         end
      end
      if (hv) h = bcd_val(new_hour);
      m_sec = h * 3600 + m * 60 + s;
   endtask

   // One clk: model advances, DUT is sampled 1 time unit after the edge.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      chk("time", {8'h00, hour, minute, second}, {8'h00, model_time()});
      chk("flags", {30'd0, ring, snoozing},
          {30'd0, (m_mode == M_RINGING), (m_mode == M_SNOOZED)});
      tick_1hz     = 1'b0;
      set_hour_stb = 1'b0;
      set_min_stb  = 1'b0;
      stop_key     = 1'b0;
      snooze_key   = 1'b0;
   endtask

   task automatic tick_pair();
      tick_1hz = 1'b1;
      step();
      step();
   endtask

   task automatic load_hour(input logic [7:0] v);
      set_hour_stb = 1'b1;
      new_hour     = v;
      step();
   endtask

   task automatic load_min(input logic [7:0] v);
      set_min_stb = 1'b1;
      new_minute  = v;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      rstn         = 1'b0;
      tick_1hz     = 1'b0;
      set_hour_stb = 1'b0;
      set_min_stb  = 1'b0;
      new_hour     = 8'h00;
      new_minute   = 8'h00;
      alarm_en     = 1'b0;
      alarm_hour   = 8'h00;
      alarm_minute = 8'h00;
      stop_key     = 1'b0;
      snooze_key   = 1'b0;
      model_reset();

      #3;
      chk("reset_time", {8'h00, hour, minute, second}, 32'h0);
      chk("reset_flags", {30'd0, ring, snoozing}, 32'h0);
      #5 rstn = 1'b1;

      // Rollover 23:59:00 -> 00:00:00 after 60 ticks
      load_hour(8'h23);
      load_min(8'h59);
      for (int i = 0; i < 60; i++) tick_pair();
      chk("rollover", {8'h00, hour, minute, second}, 32'h000000);

      // Invalid loads ignored, valid load accepted
      load_min(8'h5A);
      chk("inv_min_5a", minute, 8'h00);
      load_min(8'h60);
      chk("inv_min_60", minute, 8'h00);
      load_hour(8'h24);
      chk("inv_hour_24", hour, 8'h00);
      load_hour(8'h19);
      chk("valid_hour", hour, 8'h19);

      // Minute load coinciding with a tick at 10:15:59
      load_hour(8'h10);
      load_min(8'h15);
      for (int i = 0; i < 59; i++) tick_pair();
      set_min_stb = 1'b1;
      new_minute  = 8'h30;
      tick_1hz    = 1'b1;
      step();
      chk("min_load_tick", {8'h00, hour, minute, second}, 32'h103000);

      // Alarm at 07:00, ring timeout, then back to idle at 07:01
      alarm_hour   = 8'h07;
      alarm_minute = 8'h00;
      alarm_en     = 1'b1;
      load_hour(8'h06);
      load_min(8'h59);
      for (int i = 0; i < 59; i++) tick_pair();
      tick_1hz = 1'b1;
      step();
      chk("ring_not_yet", ring, 1'b0);
      step();
      chk("ring_start", ring, 1'b1);
      for (int i = 0; i < 59; i++) tick_pair();
      chk("ring_before_timeout", ring, 1'b1);
      tick_pair();
      chk("ring_timeout", ring, 1'b0);
      chk("timeout_time", {8'h00, hour, minute, second}, 32'h070100);

      // Snooze, re-ring after 300 ticks, stop, no re-ring
      load_min(8'h00);
      step();
      chk("ring_again", ring, 1'b1);
      snooze_key = 1'b1;
      step();
      chk("snooze_ring", ring, 1'b0);
      chk("snooze_flag", snoozing, 1'b1);
      for (int i = 0; i < 300; i++) tick_pair();
      chk("snooze_rering", ring, 1'b1);
      stop_key = 1'b1;
      step();
      chk("stop_ring", ring, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick_pair();
         seen |= ring;
      end
      chk("no_rering", seen, 1'b0);

      // Async reset mid-ring, then no ring until 00:00 is re-entered
      alarm_hour   = 8'h08;
      alarm_minute = 8'h00;
      load_hour(8'h08);
      load_min(8'h00);
      step();
      chk("ring_pre_reset", ring, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk("async_ring", ring, 1'b0);
      chk("async_time", {8'h00, hour, minute, second}, 32'h0);
      alarm_hour   = 8'h00;
      alarm_minute = 8'h00;
      model_reset();
      #1 rstn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick_pair();
         seen |= ring;
      end
      chk("no_ring_after_reset", seen, 1'b0);
      load_min(8'h00);
      step();
      chk("reenter_ring", ring, 1'b1);

      // Random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         tick_1hz   = ($urandom_range(2) == 0);
         stop_key   = ($urandom_range(199) == 0);
         snooze_key = ($urandom_range(99) == 0);
         if ($urandom_range(149) == 0) begin
            set_hour_stb = 1'b1;
            new_hour     = $urandom_range(1) ? to_bcd($urandom_range(23)) : 8'($urandom);
         end
         if ($urandom_range(149) == 0) begin
            set_min_stb = 1'b1;
            new_minute  = $urandom_range(1) ? to_bcd($urandom_range(59)) : 8'($urandom);
         end
         if ($urandom_range(59) == 0) begin
            alarm_hour   = to_bcd(m_sec / 3600);
            alarm_minute = to_bcd(((m_sec / 60) + int'($urandom_range(1))) % 60);
         end
         if ($urandom_range(399) == 0) alarm_en = ~alarm_en;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_alarm_ctrl.md
TIME_ALARM_CTRL -- requirements
Module: time_alarm_ctrl

Interface
REQ-001 Parameter RING_SECS, default 60, number of 1 Hz ticks the alarm rings before it self-stops.
REQ-002 Parameter SNOOZE_SECS, default 300, number of 1 Hz ticks from snooze to re-ring.
REQ-003 clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 tick_1hz  in  1  one-clk pulse per second, synchronous to clk.
REQ-006 set_hour_stb / set_min_stb  in  1 each  one-clk load pulses from the keypad setting FSM.
REQ-007 new_hour / new_minute  in  8 each  packed BCD load values, sampled only on their strobe.
REQ-008 alarm_en  in  1  alarm armed flag; alarm_hour / alarm_minute  in  8 each  packed BCD alarm time.
REQ-009 stop_key / snooze_key  in  1 each  one-clk user pulses.
REQ-010 hour / minute / second  out  8 each  current time, packed BCD, registered.
REQ-011 ring  out  1  buzzer enable, registered; snoozing  out  1  high in SNOOZE, registered.

Function
REQ-012 On tick_1hz, second SHALL advance in BCD: 59 wraps to 00 with carry to minute; minute 59 wraps to 00 with carry to hour; hour 23 wraps to 00. The new value is visible one clk after the tick.
REQ-013 A load with an invalid value SHALL be ignored entirely. Invalid means any digit >9, an hour >23, or a minute >59.
REQ-014 set_hour_stb with a valid value SHALL set hour; minute and second are unchanged.
REQ-015 set_min_stb with a valid value SHALL set minute and clear second to 00.
REQ-016 If a strobe and tick_1hz arrive in the same clk:
- set_hour_stb: the load wins for hour; any tick carry into hour is discarded; minute and second still advance.
- set_min_stb: the load wins; second is cleared to 00 and the tick is discarded.
REQ-017 If both strobes arrive in the same clk, both valid loads SHALL apply, and REQ-016 rules combine.
REQ-018 The ring FSM SHALL have four states: IDLE, RING, SNOOZE, HOLD.
REQ-019 Match condition: alarm_en=1, hour==alarm_hour and minute==alarm_minute, evaluated on the registered outputs.
REQ-020 IDLE -> RING when the match condition holds; ring rises the next clk.
REQ-021 RING transitions, in priority order:
- alarm_en=0 or stop_key -> HOLD;
- snooze_key -> SNOOZE, with the down-counter loaded to SNOOZE_SECS;
- RING_SECS ticks counted since entry -> HOLD.
REQ-022 SNOOZE transitions:
- stop_key or alarm_en=0 -> HOLD;
- each tick decrements the counter; the tick that reaches 0 -> RING, and the ring counter restarts.
REQ-023 HOLD -> IDLE when hour!=alarm_hour or minute!=alarm_minute; this prevents re-trigger within the alarm minute.
REQ-024 ring SHALL be 1 only in RING; snoozing SHALL be 1 only in SNOOZE.
REQ-025 A stop_key or snooze_key pulse in IDLE or HOLD SHALL have no effect.
REQ-026 A time or alarm change that produces a match while in IDLE SHALL trigger immediately.
REQ-027 Counters SHALL be sized to hold max(RING_SECS, SNOOZE_SECS) and SHALL never wrap.

Reset
REQ-028 On rstn low, asynchronously:
- hour, minute, second = 8'h00;
- FSM = HOLD; ring=0; snoozing=0; counters = 0.
HOLD prevents a ring at 00:00 just after reset with an alarm at 00:00.
REQ-029 rstn asserted mid-RING or mid-SNOOZE SHALL drop ring and snoozing within the same cycle, without waiting for a clk edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the BCD limit constants (8'h23, 8'h59) and the default parameter values.
REQ-031 One sub-module, bcd_counter60, SHALL implement the modulo-60 BCD digit pair with load, enable and carry-out; it is instantiated for second and minute. The hour counter stays inline.

Verification
REQ-032 Load 23:59 via strobes, then issue 60 ticks -> time reads 00:00:00 one clk after the 60th tick.
REQ-033 set_min_stb with new_minute=8'h5A, then with 8'h60 -> minute unchanged both times. set_hour_stb with 8'h24 -> hour unchanged.
REQ-034 Time 06:59:59, alarm 07:00 enabled, one tick -> ring=1 two clks after the tick. No stop_key applied -> ring=0 after 60 further ticks and the FSM is in HOLD. At 07:01 the FSM returns to IDLE.
REQ-035 While ringing, snooze_key -> ring=0 and snoozing=1; after 300 ticks -> ring=1 again. Then stop_key -> ring=0, and no re-ring during 300 further ticks.
REQ-036 Same-clk set_min_stb (8'h30) and tick at 10:15:59 -> reads 10:30:00.
REQ-037 rstn pulsed low mid-RING -> ring=0 immediately and time 00:00:00. With alarm 00:00 enabled, no ring occurs until the time leaves and re-enters 00:00.
